// File: rtl/load_wb_ctrl_if.sv
// Bundle of load issue, data-memory and write-back signals for load_wb_ctrl.
// The slave side is the controller; the master side is the issuing core / memory model.
interface load_wb_ctrl_if;
  logic        start;
  logic [2:0]  funct3;
  logic [63:0] addr;
  logic [4:0]  rd;
  logic        busy;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_ack;
  logic [63:0] mem_rdata;
  logic [1:0]  wrt_sel;
  logic [63:0] lane_data;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        exc_valid;
  logic [1:0]  exc_code;
  logic        done;

  modport slave (
    input  start, funct3, addr, rd, mem_ack, mem_rdata,
    output busy, mem_req, mem_addr, wrt_sel, lane_data, wb_en, wb_rd,
           wb_data, exc_valid, exc_code, done
  );

  modport master (
    output start, funct3, addr, rd, mem_ack, mem_rdata,
    input  busy, mem_req, mem_addr, wrt_sel, lane_data, wb_en, wb_rd,
           wb_data, exc_valid, exc_code, done
  );
endinterface

// File: rtl/load_wb_ctrl.sv
// Load sequencer: alignment/funct3 checks, memory read handshake, lane
// alignment and sign/zero extension of the write-back value.
module load_wb_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         reset,
  load_wb_ctrl_if.slave bus,
  output logic [1:0]   state_dbg
);

  typedef enum logic [1:0] {IDLE, REQ, WB, EXC} state_t;

  state_t      state, state_nxt;
  logic [2:0]  f3_q;
  logic [63:0] addr_q;
  logic [4:0]  rd_q;
  logic [7:0]  cnt_q;
  logic [1:0]  exc_code_q;
  logic [1:0]  wrt_sel_q;
  logic [63:0] lane_q;
  logic [63:0] wb_q;

  logic        illegal;
  logic        misaligned;
  logic        ack_take;
  logic        timeout_hit;
  logic [63:0] lane_nxt;
  logic [63:0] ext_nxt;

  always_comb begin
    illegal    = (bus.funct3 == 3'b111);
    misaligned = 1'b0;
    case (bus.funct3[1:0])
      2'b11:   misaligned = |bus.addr[2:0];
      2'b10:   misaligned = |bus.addr[1:0];
      2'b01:   misaligned = bus.addr[0];
      default: misaligned = 1'b0;
    endcase
  end

  // mem_req is held high with a stable mem_addr until the cycle mem_ack is
  // seen; mem_ack is only honoured while mem_req is high.
  assign ack_take    = (state == REQ) && bus.mem_ack;
  assign timeout_hit = (state == REQ) && !bus.mem_ack && (cnt_q == 8'(TIMEOUT - 1));

  assign lane_nxt = bus.mem_rdata >> {addr_q[2:0], 3'b000};

  always_comb begin
    ext_nxt = lane_nxt;
    case (f3_q[1:0])
      2'b00:   ext_nxt = {{56{~f3_q[2] & lane_nxt[7]}},  lane_nxt[7:0]};
      2'b01:   ext_nxt = {{48{~f3_q[2] & lane_nxt[15]}}, lane_nxt[15:0]};
      2'b10:   ext_nxt = {{32{~f3_q[2] & lane_nxt[31]}}, lane_nxt[31:0]};
      default: ext_nxt = lane_nxt;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    bus.busy      = 1'b0;
    bus.mem_req   = 1'b0;
    bus.wb_en     = 1'b0;
    bus.exc_valid = 1'b0;
    bus.done      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) state_nxt = (illegal || misaligned) ? EXC : REQ;
      end
      REQ: begin
        bus.busy    = 1'b1;
        bus.mem_req = 1'b1;
        if (ack_take)         state_nxt = WB;
        else if (timeout_hit) state_nxt = EXC;
      end
      WB: begin
        bus.busy  = 1'b1;
        bus.wb_en = 1'b1;
        bus.done  = 1'b1;
        state_nxt = IDLE;
      end
      EXC: begin
        bus.busy      = 1'b1;
        bus.exc_valid = 1'b1;
        bus.done      = 1'b1;
        state_nxt     = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      f3_q       <= 3'b000;
      addr_q     <= 64'd0;
      rd_q       <= 5'd0;
      cnt_q      <= 8'd0;
      exc_code_q <= 2'b00;
      wrt_sel_q  <= 2'b00;
      lane_q     <= 64'd0;
      wb_q       <= 64'd0;
    end else begin
      if (state == IDLE && bus.start) begin
        f3_q       <= bus.funct3;
        addr_q     <= bus.addr;
        rd_q       <= bus.rd;
        cnt_q      <= 8'd0;
        // Size select is the inverse of funct3[1:0]: ld->00 ... lb->11.
        wrt_sel_q  <= ~bus.funct3[1:0];
        exc_code_q <= illegal ? 2'b11 : (misaligned ? 2'b01 : 2'b00);
      end
      if (state == REQ) begin
        if (bus.mem_ack) begin
          lane_q <= lane_nxt;
          wb_q   <= ext_nxt;
        end else if (timeout_hit) begin
          exc_code_q <= 2'b10;
        end else begin
          cnt_q <= cnt_q + 8'd1;
        end
      end
    end
  end

  assign bus.mem_addr  = {addr_q[63:3], 3'b000};
  assign bus.wb_rd     = rd_q;
  assign bus.wrt_sel   = wrt_sel_q;
  assign bus.lane_data = lane_q;
  assign bus.wb_data   = wb_q;
  assign bus.exc_code  = exc_code_q;
  assign state_dbg     = state;

endmodule

// File: tb/tb_load_wb_ctrl.sv
// Bench for load_wb_ctrl: directed loads from the test plan, a mid-request
// reset, then random loads checked against a behavioural load model.
module tb_load_wb_ctrl;
  localparam int TO = 4;

  logic       clk;
  logic       reset;
  logic [1:0] state_dbg;
  int         n_checks;
  int         n_fail;
  logic [1:0] last_code;

  load_wb_ctrl_if bus ();

  load_wb_ctrl #(.TIMEOUT(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .state_dbg (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int size_bytes(input logic [2:0] f3);
    size_bytes = 1 << f3[1:0];
  endfunction

  function automatic logic [1:0] model_exc(input logic [2:0] f3, input logic [63:0] a);
    if (f3 == 3'b111)                          model_exc = 2'b11;
    else if ((int'(a[2:0]) % size_bytes(f3)) != 0) model_exc = 2'b01;
    else                                       model_exc = 2'b00;
  endfunction

  function automatic logic [63:0] model_wb(input logic [2:0] f3, input logic [63:0] a,
                                           input logic [63:0] d);
    int          nb;
    logic [63:0] v;
    logic [63:0] mask;
    nb = size_bytes(f3);
    v  = d >> (8 * int'(a[2:0]));
    if (nb < 8) begin
      mask = (64'd1 << (8 * nb)) - 64'd1;
      v    = v & mask;
      if (!f3[2] && v[8*nb-1]) v = v | ~mask;
    end
    model_wb = v;
  endfunction

  // One complete load; ack_dly = REQ cycles without ack before the ack,
  // ack_dly >= TO means memory never answers.
  task automatic do_load(input string nm, input logic [2:0] f3, input logic [63:0] a,
                         input logic [4:0] r, input logic [63:0] d, input int ack_dly);
    logic [1:0] ecode;
    int         req_n;
    int         done_cyc;
    bit         fin;
    logic       s_wb, s_exc;
    logic [1:0] s_code;
    logic [63:0] s_data, s_lane;
    logic [4:0] s_rd;
    logic [1:0] s_sel;
    ecode = model_exc(f3, a);
    req_n = 0;
    done_cyc = 0;
    fin = 0;
    s_wb = 0; s_exc = 0; s_code = 0; s_data = 0; s_lane = 0; s_rd = 0; s_sel = 0;

    @(negedge clk);
    check({nm, ":idle_busy"}, {63'd0, bus.busy}, 64'd0);
    check({nm, ":idle_done"}, {63'd0, bus.done}, 64'd0);
    check({nm, ":idle_wb_en"}, {63'd0, bus.wb_en}, 64'd0);
    check({nm, ":held_exc_code"}, {62'd0, bus.exc_code}, {62'd0, last_code});
    bus.start  = 1'b1;
    bus.funct3 = f3;
    bus.addr   = a;
    bus.rd     = r;

    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        bus.start  = 1'b0;
        bus.funct3 = 3'($urandom);
        bus.addr   = {$urandom, $urandom};
        bus.rd     = 5'($urandom);
      end
      check({nm, ":busy"}, {63'd0, bus.busy}, 64'd1);
      if (bus.mem_req) begin
        req_n++;
        check({nm, ":mem_addr"}, bus.mem_addr, {a[63:3], 3'b000});
        if (ack_dly < TO && req_n == ack_dly + 1) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = d;
        end else begin
          bus.mem_ack   = 1'b0;
          bus.mem_rdata = {$urandom, $urandom};
        end
      end else begin
        bus.mem_ack = 1'b0;
      end
      if (bus.done) begin
        fin = 1; done_cyc = cyc;
        s_wb = bus.wb_en; s_exc = bus.exc_valid; s_code = bus.exc_code;
        s_data = bus.wb_data; s_lane = bus.lane_data; s_rd = bus.wb_rd; s_sel = bus.wrt_sel;
        break;
      end
    end
    bus.mem_ack = 1'b0;

    if (!fin) begin
      check({nm, ":done_seen"}, 64'd0, 64'd1);
    end else if (ecode != 2'b00) begin
      check({nm, ":chk_exc_cycle"}, 64'(done_cyc), 64'd1);
      check({nm, ":chk_exc_valid"}, {63'd0, s_exc}, 64'd1);
      check({nm, ":chk_exc_code"}, {62'd0, s_code}, {62'd0, ecode});
      check({nm, ":chk_wb_en"}, {63'd0, s_wb}, 64'd0);
      check({nm, ":chk_no_req"}, 64'(req_n), 64'd0);
      last_code = ecode;
    end else if (ack_dly >= TO) begin
      check({nm, ":to_req_cycles"}, 64'(req_n), 64'(TO));
      check({nm, ":to_exc_cycle"}, 64'(done_cyc), 64'(TO + 1));
      check({nm, ":to_exc_valid"}, {63'd0, s_exc}, 64'd1);
      check({nm, ":to_exc_code"}, {62'd0, s_code}, 64'd2);
      check({nm, ":to_wb_en"}, {63'd0, s_wb}, 64'd0);
      last_code = 2'b10;
    end else begin
      check({nm, ":wb_cycle"}, 64'(done_cyc), 64'(ack_dly + 2));
      check({nm, ":req_cycles"}, 64'(req_n), 64'(ack_dly + 1));
      check({nm, ":wb_en"}, {63'd0, s_wb}, 64'd1);
      check({nm, ":exc_valid"}, {63'd0, s_exc}, 64'd0);
      check({nm, ":exc_code"}, {62'd0, s_code}, 64'd0);
      check({nm, ":wb_data"}, s_data, model_wb(f3, a, d));
      check({nm, ":lane_data"}, s_lane, d >> (8 * int'(a[2:0])));
      check({nm, ":wb_rd"}, {59'd0, s_rd}, {59'd0, r});
      check({nm, ":wrt_sel"}, {62'd0, s_sel}, 64'(3 - int'(f3[1:0])));
      last_code = 2'b00;
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    last_code = 2'b00;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.funct3 = 3'b000;
    bus.addr = 64'd0;
    bus.rd = 5'd0;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = 64'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {63'd0, bus.busy}, 64'd0);
    check("rst_mem_req", {63'd0, bus.mem_req}, 64'd0);
    check("rst_mem_addr", bus.mem_addr, 64'd0);
    check("rst_wrt_sel", {62'd0, bus.wrt_sel}, 64'd0);
    check("rst_wb_data", bus.wb_data, 64'd0);
    check("rst_exc_code", {62'd0, bus.exc_code}, 64'd0);
    check("rst_done", {63'd0, bus.done}, 64'd0);
    reset = 1'b0;

    do_load("lb",        3'b000, 64'h1003, 5'd1, 64'h0000_0000_80FF_0000, 0);
    do_load("lhu",       3'b101, 64'h1002, 5'd2, 64'h0000_0000_80FF_0000, 2);
    do_load("lw_b2b",    3'b010, 64'h1004, 5'd3, 64'h9ABC_DEF0_1234_5678, 0);
    do_load("ld_b2b",    3'b011, 64'h2000, 5'd4, 64'h9ABC_DEF0_1234_5678, 1);
    do_load("lw_misal",  3'b010, 64'h1002, 5'd5, 64'h1111_2222_3333_4444, 0);
    do_load("illegal",   3'b111, 64'h1001, 5'd6, 64'h1111_2222_3333_4444, 0);
    do_load("ld_timeout",3'b011, 64'h3008, 5'd7, 64'h5555_6666_7777_8888, TO);
    do_load("ld_ack_last",3'b011, 64'h3008, 5'd8, 64'h5555_6666_7777_8888, TO - 1);

    // Reset on the second REQ cycle with mem_ack high.
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = 3'b011; bus.addr = 64'h4000; bus.rd = 5'd9;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.mem_ack = 1'b1; bus.mem_rdata = 64'hDEAD_BEEF_CAFE_F00D;
    #1 reset = 1'b1;
    #1;
    check("mrst_mem_req", {63'd0, bus.mem_req}, 64'd0);
    check("mrst_busy", {63'd0, bus.busy}, 64'd0);
    check("mrst_wb_en", {63'd0, bus.wb_en}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("mrst_ack_ignored_wb", {63'd0, bus.wb_en}, 64'd0);
    check("mrst_ack_ignored_exc", {63'd0, bus.exc_valid}, 64'd0);
    check("mrst_ack_ignored_data", bus.wb_data, 64'd0);
    bus.mem_ack = 1'b0;
    last_code = 2'b00;
    do_load("after_rst", 3'b110, 64'h4004, 5'd10, 64'h8000_0001_0000_0000, 1);

    for (int i = 0; i < 40; i++) begin
      logic [63:0] ra;
      ra = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) ra[2:0] = 3'b000;
      do_load($sformatf("rnd%0d", i), 3'($urandom_range(0, 7)), ra, 5'($urandom),
              {$urandom, $urandom}, $urandom_range(0, TO));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/load_wb_ctrl.md
Name: load_wb_ctrl

Overview:
Sequences every load from issue to register write-back in the 64-bit RISC-V core. It checks alignment and funct3, runs the request/ack handshake with data memory, and aligns the returned doubleword to the addressed byte lane. It also drives the 2-bit size select for the datapath's write-data extension mux and produces the final sign- or zero-extended write-back value. It raises an exception code when a load cannot complete.

Parameters:
TIMEOUT, 16, max cycles mem_req stays high without mem_ack before a timeout exception (legal range 2..255)

Ports:
clk  in  1  core clock, rising edge
reset  in  1  asynchronous, active-high
start  in  1  load issue strobe, sampled only in IDLE
funct3  in  3  load type: 000 lb, 001 lh, 010 lw, 011 ld, 100 lbu, 101 lhu, 110 lwu, 111 illegal
addr  in  64  byte address of the load
rd  in  5  destination register
busy  out  1  high in every state except IDLE
mem_req  out  1  memory read request
mem_addr  out  64  doubleword-aligned address, {addr[63:3],3'b000}
mem_ack  in  1  read data valid this cycle
mem_rdata  in  64  read doubleword
wrt_sel  out  2  extension-mux select: 00 dword, 01 word, 10 half, 11 byte
lane_data  out  64  mem_rdata shifted right by 8*addr[2:0], feeds the extension mux
wb_en  out  1  register-file write strobe
wb_rd  out  5  write-back register index
wb_data  out  64  extended load result
exc_valid  out  1  one-cycle exception pulse
exc_code  out  2  01 misaligned, 10 timeout, 11 illegal funct3
done  out  1  one-cycle pulse on completion or exception

Behaviour:
- Reset (async): state IDLE. All outputs are 0, including wrt_sel=00 and exc_code=00. Internal registers and the counter clear. A mem_ack arriving after reset is ignored.
- Capture: on start in IDLE, the block registers funct3, addr, and rd. start in any other state is ignored.
- Checks in IDLE, evaluated on start:
  - Illegal funct3=111 → EXC with code 11.
  - Misaligned → EXC with code 01:
    - ld: addr[2:0]≠0
    - lw/lwu: addr[1:0]≠0
    - lh/lhu: addr[0]≠0
  - Otherwise → REQ.
  - Illegal funct3 takes precedence over misalignment.
- REQ:
  - mem_req=1 and mem_addr is valid, stable until ack.
  - The counter increments every cycle without ack.
  - On mem_ack, mem_rdata is captured → WB.
  - If there is no ack on the TIMEOUT-th REQ cycle → EXC with code 10.
  - An ack on the TIMEOUT-th cycle wins over the timeout.
  - mem_req is high for at most TIMEOUT cycles.
- WB: one cycle with wb_en=1, done=1, and wb_rd=captured rd → IDLE.
- EXC: one cycle with exc_valid=1, done=1, and exc_code set. wb_en and mem_req are both 0 → IDLE.
- exc_code holds its last value until the next start or reset. wb_data, lane_data, and wrt_sel hold their last values until the next capture.
- wrt_sel mapping from funct3[1:0]:
  - 11 → 00
  - 10 → 01
  - 01 → 10
  - 00 → 11
  - wrt_sel is driven from the registered funct3 from REQ onward.
- wb_data:
  - Lane is the low 8/16/32/64 bits of lane_data.
  - funct3[2]=0: sign-extend from the lane MSB to 64 bits, with all upper bits replicated.
  - funct3[2]=1: zero-extend.
- Latency:
  - start at cycle 0 → mem_req at cycle 1.
  - Ack at cycle k → wb_en at cycle k+1.
  - Minimum start-to-wb_en is 2 cycles.
  - Exception pulse comes 1 cycle after start for check failures.
- Back-to-back: start is accepted in the IDLE cycle immediately after the WB or EXC cycle.
- Mid-operation reset: reset in REQ drops mem_req in the same cycle (async) and produces no wb_en or exc.

Test Plan:
- lb, addr=0x1003, ack 1st REQ cycle, mem_rdata=0x0000000080FF0000 → wrt_sel=11, wb_data=0xFFFFFFFFFFFFFF80, wb_en at cycle 2, mem_addr=0x1000.
- lhu, addr=0x1002, same rdata, ack after 3 cycles → wb_data=0x00000000000080FF, wrt_sel=10, wb_en exactly 1 cycle.
- lw then ld back-to-back. lw: addr=0x1004, rdata=0x9ABCDEF012345678 → 0xFFFFFFFF9ABCDEF0. ld: addr=0x2000 → wb_data equals rdata. Second start accepted the cycle after done.
- Misaligned lw, addr=0x1002 → no mem_req, exc_valid+done at cycle 1, exc_code=01. funct3=111 with addr=0x1001 → exc_code=11.
- TIMEOUT=4, no ack → mem_req high exactly 4 cycles, then exc_code=10. Repeat with ack on 4th cycle → normal WB, no exception.
- Reset asserted on the 2nd REQ cycle with mem_ack high → outputs 0 immediately, no wb_en, busy=0; a new start after release completes normally.
